ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-requester round-robin arbiter and sequencer for the 32-bit single-port block RAM (`ram`: addr, data_in, data_out, clk, wr). It sits between two client ports (A and B) and the RAM. It serialises their read/write commands, drives the RAM's `wr`/`addr`/`data_in`, and captures the RAM's registered `data_out` for reads. Each command completes with a one-cycle acknowledge to the winning client.

## Interface
Parameters:
- ADDR_W, 5, RAM address width
- DATA_W, 32, RAM data width

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- req_a / req_b  in  1  command request; held high with command fields stable until ack
- we_a / we_b  in  1  1 = write, 0 = read
- addr_a / addr_b  in  ADDR_W  command address
- wdata_a / wdata_b  in  DATA_W  write data
- ack_a / ack_b  out  1  one-cycle completion pulse
- rdata_a / rdata_b  out  DATA_W  read result, valid when matching ack is high, held until next read for that port
- ram_wr  out  1  to RAM wr
- ram_addr  out  ADDR_W  to RAM addr
- ram_din  out  DATA_W  to RAM data_in
- ram_dout  in  DATA_W  from RAM data_out (registered in RAM, 1-cycle read latency)

## Operation
Reset value of every output is 0. State resets to IDLE and the priority pointer to A.

The FSM has three states: IDLE, ISSUE, CAPTURE.

**IDLE**
- Eligible requesters are those with req high and their own ack currently low. A client still holding req during its ack cycle is not re-granted.
- If none are eligible, remain in IDLE.
- If one is eligible, grant it.
- If both are eligible, grant the one named by the priority pointer.
- On a grant:
  - Latch the winner id.
  - Register ram_addr ← addr.
  - Register ram_din ← wdata.
  - Register ram_wr ← we.
  - Go to ISSUE.
  - Set the pointer to the loser, so after granting A, B has priority next, and vice versa. The pointer flips only on a grant.

**ISSUE**
- RAM inputs are presented for exactly this cycle.
- Write: at the edge, RAM stores. Clear ram_wr, pulse ack for the winner, go to IDLE.
- Read (ram_wr = 0): the RAM registers mem[ram_addr] at the edge. Go to CAPTURE.

**CAPTURE**
- At the edge: rdata_winner ← ram_dout, ack_winner ← 1, go to IDLE.

Other operation rules:
- ack_a/ack_b are registered, high for exactly one cycle, and never both high.
- ram_addr and ram_din hold their last value outside ISSUE. ram_wr is high only in ISSUE of a write.
- Only one command is outstanding at a time, with no pipelining across commands.
- Address is not range-checked; the full ADDR_W space is passed through.

## Timing
Latency is measured from the cycle req is first sampled in IDLE.
- Write: ack is high 2 cycles later, and RAM is written at the edge closing ISSUE.
- Read: ack and rdata are valid 3 cycles later.
- Peak throughput is one write per 2 cycles or one read per 3 cycles.
- Back-to-back behaviour: the ack cycle is an IDLE cycle, so the other client can be granted in that same cycle. There is no dead cycle between clients.

Boundary cases:
- **Simultaneous requests:** the priority pointer decides. Under continuous contention, grants strictly alternate A, B, A, B. Neither client waits more than one other command.
- **Request drop before ack:** this is illegal. The arbiter has latched the command and completes it regardless.
- **Reset mid-operation:** all state and outputs clear at that edge, and no ack is issued for the aborted command. A write already in ISSUE at the reset edge still lands in RAM, because the RAM has no reset. A read in flight is discarded.
- **Same address, write then read from different clients:** the read returns the new data, since commands are strictly ordered.

## Structure
- Package `ram_arb_pkg`: the state enum (IDLE, ISSUE, CAPTURE), ADDR_W/DATA_W defaults, and the client id constants (CLI_A = 0, CLI_B = 1).
- Sub-module `rr_arb2`: a pure 2-way round-robin picker. Inputs are eligible[1:0] and the pointer; outputs are the grant id and the valid bit.
- The FSM, command registers and ack/rdata registers live in `ram_arbiter`.
- The bench instantiates `ram_arbiter` together with `ram`.

## Test plan
- **Single write, then read.** A writes 0xDEADBEEF to addr 3, then A reads addr 3 → ack_a is 2 cycles after the write request. ram_wr is high for exactly 1 cycle. The read ack_a comes 3 cycles after its request, with rdata_a = 0xDEADBEEF.
- **Simultaneous write requests after reset.** A and B request in the same cycle: A writes 0x11 to addr 1, B writes 0x22 to addr 2 → A is granted first, then B. ack_b follows ack_a by 2 cycles. Reading back gives 0x11 and 0x22.
- **Continuous contention.** Both hold req for 8 reads each → grants alternate A, B, A, B. There are no double acks. Each ack is followed by the correct rdata for its address.
- **Write/read ordering across clients.** B writes 0xCAFEF00D to addr 31 while A requests a read of addr 31 → with the pointer at B, A's rdata = 0xCAFEF00D. Wrap-top address 31 is accepted.
- **Reset mid-read.** Assert rst_n low during CAPTURE of an A read → ack_a never pulses, all outputs are 0, and state is IDLE. The next request from B is served first, since the pointer was reset to A and only B is eligible.
- **Request held through ack.** A keeps req high during the ack cycle → no re-grant in that cycle, and a new grant occurs only on the following IDLE sample.

Source files
------------

// File: rtl/ram_arb_pkg.sv
`default_nettype none
//============================================================================
// Package : ram_arb_pkg
// Brief   : Shared constants for the two-client block-RAM arbiter: FSM state
//           encodings, default RAM geometry and client identifiers.
// Rev     : 1.0 - initial release
//============================================================================
package ram_arb_pkg;

  // Default RAM geometry (32 words x 32 bits)
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  // Sequencer states
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  // Client identifiers; also the encoding of the round-robin pointer
  localparam logic CLI_A = 1'b0;
  localparam logic CLI_B = 1'b1;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/ram.sv
`default_nettype none
//============================================================================
// Module : ram
// Brief  : Single-port block RAM, synchronous write, registered read data
//          (one-cycle latency). No reset on contents or read register.
// Rev    : 1.0 - initial release
//============================================================================
module ram #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  // Write on wr; read register always samples the addressed word
  always_ff @(posedge clk) begin
    if (wr) r_mem[addr] <= data_in;
    data_out <= r_mem[addr];
  end

endmodule : ram
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
//============================================================================
// Module : rr_arb2
// Brief  : Pure combinational 2-way round-robin picker. When both clients
//          are eligible the pointer names the winner, otherwise the single
//          eligible client wins.
// Rev    : 1.0 - initial release
//============================================================================
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       ptr,
  output logic       gnt_id,
  output logic       gnt_valid
);

  // Pick the winner: pointer breaks ties, otherwise the lone eligible client
  always_comb begin
    gnt_valid = |eligible;
    gnt_id    = CLI_A;
    if (eligible == 2'b11) begin
      gnt_id = ptr;
    end else if (eligible[1]) begin
      gnt_id = CLI_B;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
//============================================================================
// Module : ram_arbiter
// Brief  : Round-robin arbiter and command sequencer placing two client
//          ports in front of a single-port block RAM with registered read
//          data. One command outstanding at a time; each completes with a
//          one-cycle ack to its client.
// Rev    : 1.0 - initial release
//============================================================================
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  // client A
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              ack_a,
  output logic [DATA_W-1:0] rdata_a,
  // client B
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata_b,
  // RAM side
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_t              r_state;
  logic                r_ptr;
  logic                r_win;
  logic                r_ram_wr;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_din;
  logic                r_ack_a;
  logic                r_ack_b;
  logic [DATA_W-1:0]   r_rdata_a;
  logic [DATA_W-1:0]   r_rdata_b;

  logic [1:0]          w_eligible;
  logic                w_gnt_id;
  logic                w_gnt_valid;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  // A client sitting in its ack cycle is not eligible, so a held req is not
  // mistaken for a fresh command.
  assign w_eligible = {req_b & ~r_ack_b, req_a & ~r_ack_a};

  rr_arb2 u_rr_arb2 (
    .eligible  (w_eligible),
    .ptr       (r_ptr),
    .gnt_id    (w_gnt_id),
    .gnt_valid (w_gnt_valid)
  );

  // Select the winning client's command fields
  always_comb begin
    w_sel_we    = we_a;
    w_sel_addr  = addr_a;
    w_sel_wdata = wdata_a;
    if (w_gnt_id == CLI_B) begin
      w_sel_we    = we_b;
      w_sel_addr  = addr_b;
      w_sel_wdata = wdata_b;
    end
  end

  // Sequencer: grant in IDLE, present to RAM in ISSUE, collect read data in CAPTURE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= CLI_A;
      r_win      <= CLI_A;
      r_ram_wr   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_ack_a    <= 1'b0;
      r_ack_b    <= 1'b0;
      r_rdata_a  <= '0;
      r_rdata_b  <= '0;
    end else begin
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_valid) begin
            r_win      <= w_gnt_id;
            r_ram_addr <= w_sel_addr;
            r_ram_din  <= w_sel_wdata;
            r_ram_wr   <= w_sel_we;
            // loser gets priority next time
            r_ptr      <= ~w_gnt_id;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (r_ram_wr) begin
            // RAM stores at this edge; write is complete
            r_ram_wr <= 1'b0;
            if (r_win == CLI_A) r_ack_a <= 1'b1;
            else                r_ack_b <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (r_win == CLI_A) begin
            r_rdata_a <= ram_dout;
            r_ack_a   <= 1'b1;
          end else begin
            r_rdata_b <= ram_dout;
            r_ack_b   <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack_a    = r_ack_a;
  assign ack_b    = r_ack_b;
  assign rdata_a  = r_rdata_a;
  assign rdata_b  = r_rdata_b;
  assign ram_wr   = r_ram_wr;
  assign ram_addr = r_ram_addr;
  assign ram_din  = r_ram_din;

endmodule : ram_arbiter
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
//============================================================================
// Module : tb_ram_arbiter
// Brief  : Self-checking bench for ram_arbiter driving a real ram model.
//          Inputs are driven and outputs sampled on the falling edge.
// Rev    : 1.0 - initial release
//============================================================================
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, we_a, req_b, we_b;
  logic [4:0]  addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;
  logic        ack_a, ack_b;
  logic [31:0] rdata_a, rdata_b;
  logic        ram_wr;
  logic [4:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        cli;   // 0 = A, 1 = B
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;  // write data, or expected read data
    int          lat;   // expected falling edges from req to ack
  } vec_t;

  vec_t tbl [0:8];

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .ack_a(ack_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .ack_b(ack_b), .rdata_b(rdata_b),
    .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  ram #(.ADDR_W(5), .DATA_W(32)) u_ram (
    .clk(clk), .wr(ram_wr), .addr(ram_addr), .data_in(ram_din), .data_out(ram_dout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cli, input logic r, input logic w,
                       input logic [4:0] a, input logic [31:0] d);
    if (cli == 1'b0) begin
      req_a = r; we_a = w; addr_a = a; wdata_a = d;
    end else begin
      req_b = r; we_b = w; addr_b = a; wdata_b = d;
    end
  endtask

  // One command from one client; starts and ends on a falling edge
  task automatic run_single(input vec_t v, input string tag);
    int lat = 0;
    int wr_cnt = 0;
    int other = 0;
    drive(v.cli, 1'b1, v.we, v.addr, v.we ? v.data : 32'h0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ram_wr) wr_cnt++;
      if ((v.cli ? ack_a : ack_b)) other++;
      if ((v.cli ? ack_b : ack_a)) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, lat, v.lat);
    check({tag, " ram_wr cycles"}, wr_cnt, v.we ? 1 : 0);
    check({tag, " other ack"}, other, 0);
    if (!v.we) check({tag, " rdata"}, v.cli ? rdata_b : rdata_a, v.data);
    drive(v.cli, 1'b0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
  endtask

  // Acks must never overlap
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ack_a === 1'b1 && ack_b === 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL double_ack: ack_a=%b ack_b=%b, expected at most one", ack_a, ack_b);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ta, tb2, acks, last, ia, ib;
    logic expn, who;
    vec_t v;

    tbl[0] = '{1'b0, 1'b1, 5'd3,  32'hDEADBEEF, 2};
    tbl[1] = '{1'b0, 1'b0, 5'd3,  32'hDEADBEEF, 3};
    tbl[2] = '{1'b0, 1'b0, 5'd1,  32'h00000011, 3};
    tbl[3] = '{1'b1, 1'b0, 5'd2,  32'h00000022, 3};
    tbl[4] = '{1'b1, 1'b0, 5'd3,  32'hDEADBEEF, 3};
    tbl[5] = '{1'b1, 1'b1, 5'd0,  32'h12345678, 2};
    tbl[6] = '{1'b0, 1'b0, 5'd0,  32'h12345678, 3};
    tbl[7] = '{1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 2};
    tbl[8] = '{1'b1, 1'b0, 5'd31, 32'hFFFFFFFF, 3};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    repeat (3) @(negedge clk);

    // Reset state
    check("reset ack_a", ack_a, 0);
    check("reset ack_b", ack_b, 0);
    check("reset ram_wr", ram_wr, 0);
    check("reset ram_addr", ram_addr, 0);
    check("reset ram_din", ram_din, 0);
    check("reset rdata_a", rdata_a, 0);
    check("reset rdata_b", rdata_b, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Simultaneous writes right after reset: A first, B two cycles later
    drive(1'b0, 1'b1, 1'b1, 5'd1, 32'h11);
    drive(1'b1, 1'b1, 1'b1, 5'd2, 32'h22);
    ta = 0; tb2 = 0;
    for (int k = 1; k <= 20 && (ta == 0 || tb2 == 0); k++) begin
      @(negedge clk);
      if (ack_a && ta == 0)  begin ta = k;  drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0); end
      if (ack_b && tb2 == 0) begin tb2 = k; drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0); end
    end
    check("simul ack_a cycle", ta, 2);
    check("simul ack_b cycle", tb2, 4);
    @(negedge clk);

    // Single-client directed vectors
    for (int i = 0; i <= 8; i++) run_single(tbl[i], $sformatf("vec%0d", i));

    // Prefill 8..23 from A (last grant A leaves the pointer at B)
    for (int i = 8; i <= 23; i++) begin
      v = '{1'b0, 1'b1, 5'(i), 32'hA5000000 + 32'(i), 2};
      run_single(v, $sformatf("fill%0d", i));
    end

    // Continuous contention: 8 reads each, strict alternation starting with B
    ia = 0; ib = 0; acks = 0; last = 0; expn = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 5'd8,  32'h0);
    drive(1'b1, 1'b1, 1'b0, 5'd16, 32'h0);
    for (int k = 1; k <= 200 && acks < 16; k++) begin
      @(negedge clk);
      if (ack_a || ack_b) begin
        who = ack_b;
        check($sformatf("cont%0d winner", acks), who, expn);
        check($sformatf("cont%0d spacing", acks), k - last, 3);
        if (who) begin
          check($sformatf("cont%0d rdata_b", acks), rdata_b, 32'hA5000000 + 32'(16 + ib));
          ib++;
          if (ib == 8) drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
          else         drive(1'b1, 1'b1, 1'b0, 5'(16 + ib), 32'h0);
        end else begin
          check($sformatf("cont%0d rdata_a", acks), rdata_a, 32'hA5000000 + 32'(8 + ia));
          ia++;
          if (ia == 8) drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
          else         drive(1'b0, 1'b1, 1'b0, 5'(8 + ia), 32'h0);
        end
        expn = ~who;
        last = k;
        acks++;
      end
    end
    check("cont ack count", acks, 16);
    @(negedge clk);

    // Pointer at B: B writes addr 31, A's read of 31 sees the new data
    drive(1'b1, 1'b1, 1'b1, 5'd31, 32'hCAFEF00D);
    drive(1'b0, 1'b1, 1'b0, 5'd31, 32'h0);
    ta = 0; tb2 = 0;
    for (int k = 1; k <= 20 && (ta == 0 || tb2 == 0); k++) begin
      @(negedge clk);
      if (ack_a && ta == 0)  begin ta = k;  drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0); end
      if (ack_b && tb2 == 0) begin tb2 = k; drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0); end
    end
    check("order ack_b cycle", tb2, 2);
    check("order ack_a cycle", ta, 5);
    check("order rdata_a", rdata_a, 32'hCAFEF00D);
    @(negedge clk);

    // Reset during CAPTURE of an A read
    drive(1'b0, 1'b1, 1'b0, 5'd9, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("mid-reset ack_a", ack_a, 0);
    check("mid-reset ram_addr", ram_addr, 0);
    check("mid-reset ram_din", ram_din, 0);
    check("mid-reset rdata_a", rdata_a, 0);
    check("mid-reset rdata_b", rdata_b, 0);
    rst_n = 1'b1;
    ta = 0;
    v = '{1'b1, 1'b0, 5'd17, 32'hA5000011, 3};
    run_single(v, "post-reset B read");
    check("post-reset rdata_a held", rdata_a, 0);

    // A holds req through its ack: no re-grant in the ack cycle
    drive(1'b0, 1'b1, 1'b1, 5'd5, 32'h55);
    repeat (2) @(negedge clk);
    check("hold first ack_a", ack_a, 1);
    @(negedge clk);
    check("hold ack_a cleared", ack_a, 0);
    check("hold no issue in ack cycle", ram_wr, 0);
    @(negedge clk);
    check("hold regrant ram_wr", ram_wr, 1);
    check("hold regrant ram_addr", ram_addr, 5);
    @(negedge clk);
    check("hold second ack_a", ack_a, 1);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    v = '{1'b1, 1'b0, 5'd5, 32'h00000055, 3};
    run_single(v, "hold readback");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_ram_arbiter
`default_nettype wire
